// File: rtl/sfp_rx_link_ctrl.sv
// rtl/sfp_rx_link_ctrl.sv - comma-lock, error-rate monitor and GT reset request for the SFP 8b10b RX path
module sfp_rx_link_ctrl #(
  parameter int LOCK_CNT     = 16,
  parameter int ERR_WINDOW   = 1024,
  parameter int ERR_THRESH   = 8,
  parameter int HUNT_TIMEOUT = 65536,
  parameter int RST_CYCLES   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rx_data_in,
  input  logic [3:0]  rx_charisk_in,
  input  logic [3:0]  rx_err_in,
  output logic [31:0] rx_data_out,
  output logic        rx_valid_out,
  output logic        link_up,
  output logic        gt_rx_reset,
  output logic [15:0] err_cnt
);

  localparam int CC_W   = $clog2(LOCK_CNT + 1);
  localparam int TO_W   = $clog2(HUNT_TIMEOUT + 1);
  localparam int WIN_W  = $clog2(ERR_WINDOW + 1);
  localparam int WERR_W = $clog2(ERR_THRESH + 1);
  localparam int RST_W  = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED, RESET_GT} state_t;
  state_t state, next_state;

  logic [CC_W-1:0]   comma_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [WERR_W-1:0] werr_cnt;
  logic [WERR_W-1:0] werr_next;
  logic [RST_W-1:0]  rst_cnt;

  logic is_comma, is_err, is_data;
  logic in_search, timeout, comma_done, win_wrap, thresh_hit, rst_done;

  assign is_comma = (rx_charisk_in == 4'b0001) && (rx_data_in[7:0] == 8'hBC) && (rx_err_in == 4'b0000);
  assign is_err   = (|rx_err_in) || ((rx_charisk_in != 4'b0000) && !is_comma);
  assign is_data  = (rx_charisk_in == 4'b0000) && (rx_err_in == 4'b0000);

  assign in_search  = (state == HUNT) || (state == VERIFY);
  assign timeout    = (to_cnt == TO_W'(HUNT_TIMEOUT - 1));
  // comma_cnt is 0 in HUNT, so LOCK_CNT==1 locks straight from HUNT
  assign comma_done = is_comma && (comma_cnt == CC_W'(LOCK_CNT - 1));
  assign win_wrap   = (win_cnt == WIN_W'(ERR_WINDOW - 1));
  // an error on the wrap cycle is the first error of the new window
  assign werr_next  = win_wrap ? WERR_W'(is_err) : werr_cnt + WERR_W'(is_err);
  assign thresh_hit = is_err && (werr_next == WERR_W'(ERR_THRESH));
  assign rst_done   = (rst_cnt == RST_W'(RST_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      HUNT, VERIFY: begin
        if (timeout)         next_state = RESET_GT;
        else if (comma_done) next_state = LOCKED;
        else if (is_comma)   next_state = VERIFY;
        else if (is_err)     next_state = HUNT;
      end
      LOCKED:   if (thresh_hit) next_state = HUNT;
      RESET_GT: if (rst_done)   next_state = HUNT;
    endcase
  end

  always_comb begin
    gt_rx_reset = (state == RESET_GT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comma_cnt    <= '0;
      to_cnt       <= '0;
      win_cnt      <= '0;
      werr_cnt     <= '0;
      rst_cnt      <= '0;
      rx_data_out  <= '0;
      rx_valid_out <= 1'b0;
      link_up      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      if (next_state != VERIFY) comma_cnt <= '0;
      else if (is_comma)        comma_cnt <= comma_cnt + CC_W'(1);

      if (in_search && (next_state == HUNT || next_state == VERIFY)) to_cnt <= to_cnt + TO_W'(1);
      else                                                           to_cnt <= '0;

      if (state == LOCKED && next_state == LOCKED) begin
        win_cnt  <= win_wrap ? '0 : win_cnt + WIN_W'(1);
        werr_cnt <= werr_next;
      end else begin
        win_cnt  <= '0;
        werr_cnt <= '0;
      end

      if (state == RESET_GT && next_state == RESET_GT) rst_cnt <= rst_cnt + RST_W'(1);
      else                                             rst_cnt <= '0;

      rx_data_out  <= rx_data_in;
      rx_valid_out <= (state == LOCKED) && is_data;
      link_up      <= (next_state == LOCKED);
      if (state == LOCKED && is_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sfp_rx_link_ctrl.sv
// tb/tb_sfp_rx_link_ctrl.sv - self-checking bench for sfp_rx_link_ctrl
module tb_sfp_rx_link_ctrl;

  localparam int LOCK_CNT     = 16;
  localparam int ERR_WINDOW   = 1024;
  localparam int ERR_THRESH   = 8;
  localparam int HUNT_TIMEOUT = 65536;
  localparam int RST_CYCLES   = 32;
  localparam int B_TIMEOUT    = 100;
  localparam int B_RST        = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [31:0] rx_data_in = '0;
  logic [3:0]  rx_charisk_in = '0, rx_err_in = '0;
  logic [31:0] rx_data_out;
  logic        rx_valid_out, link_up, gt_rx_reset;
  logic [15:0] err_cnt;

  logic        rst_b = 1'b0;
  logic [31:0] data_b = '0;
  logic [3:0]  k_b = '0, e_b = '0;
  logic [31:0] data_out_b;
  logic        valid_b, link_b, gt_b;
  logic [15:0] err_b;

  sfp_rx_link_ctrl #(
    .LOCK_CNT(LOCK_CNT), .ERR_WINDOW(ERR_WINDOW), .ERR_THRESH(ERR_THRESH),
    .HUNT_TIMEOUT(HUNT_TIMEOUT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_in(rx_data_in), .rx_charisk_in(rx_charisk_in),
    .rx_err_in(rx_err_in), .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out),
    .link_up(link_up), .gt_rx_reset(gt_rx_reset), .err_cnt(err_cnt)
  );

  // second instance: short timeout, threshold above the window so errors never unlock
  sfp_rx_link_ctrl #(
    .LOCK_CNT(16), .ERR_WINDOW(1024), .ERR_THRESH(2000),
    .HUNT_TIMEOUT(B_TIMEOUT), .RST_CYCLES(B_RST)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .rx_data_in(data_b), .rx_charisk_in(k_b),
    .rx_err_in(e_b), .rx_data_out(data_out_b), .rx_valid_out(valid_b),
    .link_up(link_b), .gt_rx_reset(gt_b), .err_cnt(err_b)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: search / locked / resetting with ages and per-window error tallies
  int          m_mode;
  int          m_run, m_age, m_t, m_left;
  int          m_wcount[int];
  logic [15:0] m_errs;
  logic        m_valid;
  logic [31:0] m_data;

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_age = 0; m_t = 0; m_left = 0;
    m_wcount.delete();
    m_errs = '0; m_valid = 1'b0; m_data = '0;
  endtask

  task automatic model_step(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e);
    bit comma, err, dat;
    int w;
    comma = (k == 4'b0001) && (d[7:0] == 8'hBC) && (e == 4'b0000);
    err   = (e != 4'b0000) || ((k != 4'b0000) && !comma);
    dat   = (k == 4'b0000) && (e == 4'b0000);
    m_data  = d;
    m_valid = (m_mode == 1) && dat;
    case (m_mode)
      0: begin
        if (m_age == HUNT_TIMEOUT - 1) begin
          m_mode = 2; m_left = RST_CYCLES; m_run = 0;
        end else begin
          m_age++;
          if (comma) begin
            m_run++;
            if (m_run == LOCK_CNT) begin
              m_mode = 1; m_t = 0; m_wcount.delete();
            end
          end else if (err) m_run = 0;
        end
      end
      1: begin
        if (err) begin
          if (m_errs != 16'hFFFF) m_errs++;
          w = m_t / ERR_WINDOW;
          if (!m_wcount.exists(w)) m_wcount[w] = 0;
          m_wcount[w]++;
          if (m_wcount[w] >= ERR_THRESH) begin
            m_mode = 0; m_run = 0; m_age = 0;
          end
        end
        m_t++;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0; m_age = 0; m_run = 0;
        end
      end
    endcase
  endtask

  task automatic cyc(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e);
    rx_data_in = d; rx_charisk_in = k; rx_err_in = e;
    @(posedge clk);
    model_step(d, k, e);
    #1;
  endtask

  task automatic reset_main();
    rx_data_in = '0; rx_charisk_in = '0; rx_err_in = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic commas(input int n);
    for (int i = 0; i < n; i++) cyc(32'h0000_00BC, 4'b0001, 4'b0000);
  endtask

  task automatic cyc_b(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e);
    data_b = d; k_b = k; e_b = e;
    @(posedge clk); #1;
  endtask

  task automatic reset_b();
    data_b = '0; k_b = '0; e_b = '0;
    rst_b = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  e;
    logic        link;
    logic        valid;
    logic [31:0] odata;
    logic [15:0] errs;
  } vec_t;

  function automatic vec_t mk(logic [31:0] d, logic [3:0] k, logic [3:0] e,
                              logic link, logic valid, logic [15:0] errs);
    vec_t v;
    v.d = d; v.k = k; v.e = e; v.link = link; v.valid = valid; v.odata = d; v.errs = errs;
    return v;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_link"},  32'(link_up),      32'(m_mode == 1));
    chk({tag, "_gt"},    32'(gt_rx_reset),  32'(m_mode == 2));
    chk({tag, "_valid"}, 32'(rx_valid_out), 32'(m_valid));
    chk({tag, "_data"},  rx_data_out,       m_data);
    chk({tag, "_err"},   32'(err_cnt),      32'(m_errs));
  endtask

  task automatic rand_phase();
    int kind, perr, r;
    logic [31:0] d;
    logic [3:0] k, e;
    reset_main();
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 2);
      perr = (kind == 0) ? 0 : (kind == 1) ? 2 : 20;
      for (int c = 0; c < 150; c++) begin
        r = $urandom_range(0, 99);
        if (r < perr) begin
          case ($urandom_range(0, 2))
            0: begin d = $urandom; k = 4'($urandom_range(0, 15)); e = 4'($urandom_range(1, 15)); end
            1: begin d = $urandom; k = 4'($urandom_range(2, 15)); e = 4'b0000; end
            default: begin d = {24'($urandom), 8'($urandom_range(0, 187))}; k = 4'b0001; e = 4'b0000; end
          endcase
        end else if (r < perr + 60) begin
          d = {24'($urandom), 8'hBC}; k = 4'b0001; e = 4'b0000;
        end else begin
          d = $urandom; k = 4'b0000; e = 4'b0000;
        end
        cyc(d, k, e);
        check_model("rnd");
      end
    end
  endtask

  task automatic thread_main();
    vec_t tbl[$];
    int n, w;
    bit found;

    // reset state
    reset_main();
    chk("rst_link", 32'(link_up), 0);
    chk("rst_valid", 32'(rx_valid_out), 0);
    chk("rst_gt", 32'(gt_rx_reset), 0);
    chk("rst_data", rx_data_out, 0);
    chk("rst_err", 32'(err_cnt), 0);

    // lock, then data/comma/error mix
    for (int i = 1; i <= 16; i++) tbl.push_back(mk(32'h0000_00BC, 4'b0001, 4'b0000, i == 16, 1'b0, 16'd0));
    tbl.push_back(mk(32'h1234_5678, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'd0));
    tbl.push_back(mk(32'hFFEE_00BC, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'd0));
    tbl.push_back(mk(32'hA5A5_0F0F, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'd0));
    tbl.push_back(mk(32'h0000_0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 16'd1));
    tbl.push_back(mk(32'h0000_00BC, 4'b0011, 4'b0000, 1'b1, 1'b0, 16'd2));
    tbl.push_back(mk(32'h0000_00BD, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'd3));
    tbl.push_back(mk(32'hDEAD_BEEF, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'd3));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].d, tbl[i].k, tbl[i].e);
      chk($sformatf("tbl%0d_link", i), 32'(link_up), 32'(tbl[i].link));
      chk($sformatf("tbl%0d_valid", i), 32'(rx_valid_out), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_data", i), rx_data_out, tbl[i].odata);
      chk($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'(tbl[i].errs));
    end

    // 15 commas + error restarts the run; data inside VERIFY holds the count
    reset_main();
    commas(15);
    chk("c15_link", 32'(link_up), 0);
    cyc(32'h0000_0000, 4'b0000, 4'b1000);
    chk("c15err_link", 32'(link_up), 0);
    commas(8);
    cyc(32'h1111_2222, 4'b0000, 4'b0000);
    cyc(32'h3333_4444, 4'b0000, 4'b0000);
    commas(7);
    chk("c8d2c7_link", 32'(link_up), 0);
    commas(1);
    chk("c8d2c8_link", 32'(link_up), 1);

    // 7 errors keep lock, 8th in the same window drops it
    for (int i = 0; i < 7; i++) begin
      cyc(32'h0, 4'b0100, 4'b0000);
      cyc(32'h5555_AAAA, 4'b0000, 4'b0000);
    end
    chk("e7_link", 32'(link_up), 1);
    chk("e7_err", 32'(err_cnt), 7);
    cyc(32'h0, 4'b0000, 4'b0001);
    chk("e8_link", 32'(link_up), 0);
    chk("e8_err", 32'(err_cnt), 8);
    cyc(32'h7777_8888, 4'b0000, 4'b0000);
    chk("e8_valid_after", 32'(rx_valid_out), 0);

    // 7 errors, window wrap, 7 more stay locked; one more drops
    reset_main();
    commas(16);
    for (int t = 0; t < 1031; t++) begin
      if (t < 7 || t >= 1024) cyc(32'h0, 4'b0000, 4'b0100);
      else                    cyc(32'($urandom), 4'b0000, 4'b0000);
    end
    chk("wrap_link", 32'(link_up), 1);
    chk("wrap_err", 32'(err_cnt), 14);
    cyc(32'h0, 4'b0000, 4'b0100);
    chk("wrap_e8_link", 32'(link_up), 0);

    // async reset while locked
    reset_main();
    commas(16);
    cyc(32'hCAFE_F00D, 4'b0000, 4'b0000);
    cyc(32'h0, 4'b1000, 4'b0000);
    chk("pre_arst_err", 32'(err_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_link", 32'(link_up), 0);
    chk("arst_data", rx_data_out, 0);
    chk("arst_err", 32'(err_cnt), 0);
    chk("arst_valid", 32'(rx_valid_out), 0);
    chk("arst_gt", 32'(gt_rx_reset), 0);

    // misaligned K forever -> GT reset after HUNT_TIMEOUT cycles, RST_CYCLES wide, then relock
    reset_main();
    n = 0; found = 0;
    for (int i = 1; i <= HUNT_TIMEOUT + 1000 && !found; i++) begin
      cyc(32'h0000_00BC, 4'b0100, 4'b0000);
      if (gt_rx_reset) begin found = 1; n = i; end
    end
    chk("timeout_cycles", 32'(n), 32'(HUNT_TIMEOUT));
    w = found ? 1 : 0;
    for (int i = 0; i < 4 * RST_CYCLES && gt_rx_reset; i++) begin
      cyc(32'h0000_00BC, 4'b0100, 4'b0000);
      if (gt_rx_reset) w++;
    end
    chk("gt_width", 32'(w), 32'(RST_CYCLES));
    commas(15);
    chk("relock15_link", 32'(link_up), 0);
    commas(1);
    chk("relock16_link", 32'(link_up), 1);

    rand_phase();
  endtask

  task automatic thread_b();
    int n;
    bit found;
    reset_b();
    n = 0; found = 0;
    for (int i = 1; i <= B_TIMEOUT + 50 && !found; i++) begin
      cyc_b(32'h0, 4'b0100, 4'b0000);
      if (gt_b) begin found = 1; n = i; end
    end
    chk("b_timeout_cycles", 32'(n), 32'(B_TIMEOUT));
    cyc_b(32'h0, 4'b0100, 4'b0000);
    cyc_b(32'h0, 4'b0100, 4'b0000);
    chk("b_gt_mid", 32'(gt_b), 1);
    #2 rst_b = 1'b0;
    #1;
    chk("b_arst_gt", 32'(gt_b), 0);
    chk("b_arst_link", 32'(link_b), 0);
    reset_b();
    for (int i = 0; i < 16; i++) cyc_b(32'h1234_00BC, 4'b0001, 4'b0000);
    chk("b_lock", 32'(link_b), 1);
    for (int i = 1; i <= 65540; i++) begin
      cyc_b(32'($urandom), 4'b0010, 4'b0000);
      if (i == 65534) chk("b_err_fffe", 32'(err_b), 32'h0000_FFFE);
      if (i == 65535) chk("b_err_ffff", 32'(err_b), 32'h0000_FFFF);
    end
    chk("b_err_sat", 32'(err_b), 32'h0000_FFFF);
    chk("b_link_end", 32'(link_b), 1);
  endtask

  initial begin
    fork
      thread_main();
      thread_b();
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
